host_wg_dispatcher: RTL and testbench

Synthesizable kernel-launch engine between the host command path and the GPGPU workgroup allocator. It accepts one kernel descriptor and issues `num_wg` workgroup requests with sequential IDs. Each request carries per-workgroup PDS addresses and derived resource totals. The block also tracks in-flight workgroups against a credit limit, drains completions, and signals kernel completion.

---
 rtl/host_wg_dispatcher.sv | 257 +++++++++++++++++++++++++
 tb/tb_host_wg_dispatcher.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_wg_dispatcher.sv
// host_wg_dispatcher: issues num_wg sequential workgroup requests for one kernel under an in-flight credit limit.
// Optional completion checking (bitmap + sticky err) is compiled in with HOST_DISPATCH_CHK_EN.
`default_nettype none
`timescale 1ns/1ps

module host_wg_dispatcher #(
   parameter int WG_ID_W      = 8,
   parameter int WF_CNT_W     = 3,
   parameter int WAVE_ITEM_W  = 6,
   parameter int ADDR_W       = 32,
   parameter int VGPR_W       = 11,
   parameter int SGPR_W       = 11,
   parameter int LDS_W        = 11,
   parameter int MAX_INFLIGHT = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,

   input  logic                              knl_valid,
   output logic                              knl_ready,
   input  logic [WG_ID_W:0]                  knl_num_wg,
   input  logic [WF_CNT_W-1:0]               knl_num_wf,
   input  logic [WAVE_ITEM_W-1:0]            knl_wf_size,
   input  logic [ADDR_W-1:0]                 knl_start_pc,
   input  logic [ADDR_W-1:0]                 knl_pds_base,
   input  logic [ADDR_W-1:0]                 knl_pds_stride,
   input  logic [ADDR_W-1:0]                 knl_csr,
   input  logic [VGPR_W-1:0]                 knl_vgpr_per_wf,
   input  logic [SGPR_W-1:0]                 knl_sgpr_per_wf,
   input  logic [LDS_W-1:0]                  knl_lds_total,

   output logic                              host_req_valid,
   input  logic                              host_req_ready,
   output logic [WG_ID_W-1:0]                host_req_wg_id,
   output logic [WF_CNT_W-1:0]               host_req_num_wf,
   output logic [WAVE_ITEM_W-1:0]            host_req_wf_size,
   output logic [ADDR_W-1:0]                 host_req_start_pc,
   output logic [ADDR_W-1:0]                 host_req_pds_baseaddr,
   output logic [ADDR_W-1:0]                 host_req_csr_knl,
   output logic [VGPR_W-1:0]                 host_req_vgpr_size_total,
   output logic [SGPR_W-1:0]                 host_req_sgpr_size_total,
   output logic [LDS_W-1:0]                  host_req_lds_size_total,
   output logic [VGPR_W-1:0]                 host_req_vgpr_size_per_wf,
   output logic [SGPR_W-1:0]                 host_req_sgpr_size_per_wf,

   input  logic                              host_rsp_valid,
   output logic                              host_rsp_ready,
   input  logic [WG_ID_W-1:0]                host_rsp_wg_id,

   output logic                              busy,
   output logic                              kernel_done,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_cnt,
   output logic                              err
);

   localparam int IW = $clog2(MAX_INFLIGHT+1);
   localparam int NW = WG_ID_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;

   logic [NW-1:0]             r_num_wg;
   logic [NW-1:0]             r_issued;
   logic [NW-1:0]             r_completed;
   logic [IW-1:0]             r_inflight;
   logic [ADDR_W-1:0]         r_pds_stride;

   logic [WG_ID_W-1:0]        r_wg_id;
   logic [WF_CNT_W-1:0]       r_num_wf;
   logic [WAVE_ITEM_W-1:0]    r_wf_size;
   logic [ADDR_W-1:0]         r_start_pc;
   logic [ADDR_W-1:0]         r_pds_addr;
   logic [ADDR_W-1:0]         r_csr;
   logic [VGPR_W-1:0]         r_vgpr_total;
   logic [SGPR_W-1:0]         r_sgpr_total;
   logic [LDS_W-1:0]          r_lds_total;
   logic [VGPR_W-1:0]         r_vgpr_per_wf;
   logic [SGPR_W-1:0]         r_sgpr_per_wf;
   logic                      r_busy;
   logic                      r_kernel_done;

   logic                      w_launch;
   logic                      w_req_fire;
   logic                      w_rsp_live;
   logic                      w_rsp_fire;
   logic                      w_last_issue;
   logic [NW-1:0]             w_completed_nxt;
   logic [WF_CNT_W+VGPR_W-1:0] w_vgpr_prod;
   logic [WF_CNT_W+SGPR_W-1:0] w_sgpr_prod;

   assign w_vgpr_prod = knl_num_wf * knl_vgpr_per_wf;
   assign w_sgpr_prod = knl_num_wf * knl_sgpr_per_wf;

   assign w_launch     = knl_ready & knl_valid;
   assign w_req_fire   = host_req_valid & host_req_ready;
   assign w_rsp_live   = host_rsp_valid & ((r_state == S_ISSUE) || (r_state == S_DRAIN))
                         & (r_inflight != IW'(0));
   assign w_last_issue = w_req_fire & ((r_issued + NW'(1)) == r_num_wg);

`ifdef HOST_DISPATCH_CHK_EN
   logic [(2**WG_ID_W)-1:0]   r_bitmap;
   logic                      r_err;
   logic                      w_rsp_bad_id;
   logic                      w_rsp_dup;
   logic                      w_rsp_err;

   assign w_rsp_bad_id = ({1'b0, host_rsp_wg_id} >= r_issued);
   assign w_rsp_dup    = r_bitmap[host_rsp_wg_id];
   assign w_rsp_err    = host_rsp_valid & (~w_rsp_live | w_rsp_bad_id | w_rsp_dup);
   assign w_rsp_fire   = w_rsp_live & ~w_rsp_bad_id & ~w_rsp_dup;
   assign err          = r_err;

   // A launch clears the history even if a stray completion lands in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bitmap <= '0;
         r_err    <= 1'b0;
      end else if (w_launch) begin
         r_bitmap <= '0;
         r_err    <= 1'b0;
      end else begin
         if (w_rsp_fire)
            r_bitmap[host_rsp_wg_id] <= 1'b1;
         if (w_rsp_err)
            r_err <= 1'b1;
      end
   end
`else
   logic w_unused_rsp_id;

   assign w_unused_rsp_id = ^host_rsp_wg_id;
   assign w_rsp_fire      = w_rsp_live;
   assign err             = 1'b0;
`endif

   assign w_completed_nxt = r_completed + NW'(w_rsp_fire);

   always_comb begin
      w_state_nxt    = r_state;
      knl_ready      = 1'b0;
      host_req_valid = 1'b0;
      host_rsp_ready = 1'b1;
      case (r_state)
         S_IDLE: begin
            knl_ready = 1'b1;
            if (knl_valid)
               w_state_nxt = (knl_num_wg == NW'(0)) ? S_DONE : S_ISSUE;
         end
         S_ISSUE: begin
            host_req_valid = (r_inflight < IW'(MAX_INFLIGHT));
            if (w_last_issue)
               w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_completed_nxt == r_num_wg)
               w_state_nxt = S_DONE;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_num_wg      <= '0;
         r_issued      <= '0;
         r_completed   <= '0;
         r_inflight    <= '0;
         r_pds_stride  <= '0;
         r_wg_id       <= '0;
         r_num_wf      <= '0;
         r_wf_size     <= '0;
         r_start_pc    <= '0;
         r_pds_addr    <= '0;
         r_csr         <= '0;
         r_vgpr_total  <= '0;
         r_sgpr_total  <= '0;
         r_lds_total   <= '0;
         r_vgpr_per_wf <= '0;
         r_sgpr_per_wf <= '0;
         r_busy        <= 1'b0;
         r_kernel_done <= 1'b0;
      end else begin
         r_busy        <= (w_state_nxt != S_IDLE);
         r_kernel_done <= (w_state_nxt == S_DONE);

         if (w_launch) begin
            r_num_wg      <= knl_num_wg;
            r_issued      <= '0;
            r_completed   <= '0;
            r_pds_stride  <= knl_pds_stride;
            r_wg_id       <= '0;
            r_num_wf      <= knl_num_wf;
            r_wf_size     <= knl_wf_size;
            r_start_pc    <= knl_start_pc;
            r_pds_addr    <= knl_pds_base;
            r_csr         <= knl_csr;
            r_vgpr_total  <= w_vgpr_prod[VGPR_W-1:0];
            r_sgpr_total  <= w_sgpr_prod[SGPR_W-1:0];
            r_lds_total   <= knl_lds_total;
            r_vgpr_per_wf <= knl_vgpr_per_wf;
            r_sgpr_per_wf <= knl_sgpr_per_wf;
         end else begin
            if (w_req_fire) begin
               r_wg_id    <= r_wg_id + WG_ID_W'(1);
               r_pds_addr <= r_pds_addr + r_pds_stride;
               r_issued   <= r_issued + NW'(1);
            end
            if (w_rsp_fire)
               r_completed <= w_completed_nxt;
         end

         // A simultaneous issue and completion cancel out on the credit count.
         case ({w_req_fire, w_rsp_fire})
            2'b10:   r_inflight <= r_inflight + IW'(1);
            2'b01:   r_inflight <= r_inflight - IW'(1);
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   assign host_req_wg_id            = r_wg_id;
   assign host_req_num_wf           = r_num_wf;
   assign host_req_wf_size          = r_wf_size;
   assign host_req_start_pc         = r_start_pc;
   assign host_req_pds_baseaddr     = r_pds_addr;
   assign host_req_csr_knl          = r_csr;
   assign host_req_vgpr_size_total  = r_vgpr_total;
   assign host_req_sgpr_size_total  = r_sgpr_total;
   assign host_req_lds_size_total   = r_lds_total;
   assign host_req_vgpr_size_per_wf = r_vgpr_per_wf;
   assign host_req_sgpr_size_per_wf = r_sgpr_per_wf;
   assign busy                      = r_busy;
   assign kernel_done               = r_kernel_done;
   assign inflight_cnt              = r_inflight;

endmodule

`default_nettype wire

// File: tb/tb_host_wg_dispatcher.sv
// tb_host_wg_dispatcher: directed self-checking bench for host_wg_dispatcher.
`default_nettype none
`timescale 1ns/1ps

module tb_host_wg_dispatcher;

`ifdef HOST_DISPATCH_CHK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        knl_valid;
   logic        knl_ready;
   logic [8:0]  knl_num_wg;
   logic [2:0]  knl_num_wf;
   logic [5:0]  knl_wf_size;
   logic [31:0] knl_start_pc;
   logic [31:0] knl_pds_base;
   logic [31:0] knl_pds_stride;
   logic [31:0] knl_csr;
   logic [10:0] knl_vgpr_per_wf;
   logic [10:0] knl_sgpr_per_wf;
   logic [10:0] knl_lds_total;
   logic        host_req_valid;
   logic        host_req_ready;
   logic [7:0]  host_req_wg_id;
   logic [2:0]  host_req_num_wf;
   logic [5:0]  host_req_wf_size;
   logic [31:0] host_req_start_pc;
   logic [31:0] host_req_pds_baseaddr;
   logic [31:0] host_req_csr_knl;
   logic [10:0] host_req_vgpr_size_total;
   logic [10:0] host_req_sgpr_size_total;
   logic [10:0] host_req_lds_size_total;
   logic [10:0] host_req_vgpr_size_per_wf;
   logic [10:0] host_req_sgpr_size_per_wf;
   logic        host_rsp_valid;
   logic        host_rsp_ready;
   logic [7:0]  host_rsp_wg_id;
   logic        busy;
   logic        kernel_done;
   logic [3:0]  inflight_cnt;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;
   int n_req;

   host_wg_dispatcher u_dut (
      .clk                       (clk),
      .rst_n                     (rst_n),
      .knl_valid                 (knl_valid),
      .knl_ready                 (knl_ready),
      .knl_num_wg                (knl_num_wg),
      .knl_num_wf                (knl_num_wf),
      .knl_wf_size               (knl_wf_size),
      .knl_start_pc              (knl_start_pc),
      .knl_pds_base              (knl_pds_base),
      .knl_pds_stride            (knl_pds_stride),
      .knl_csr                   (knl_csr),
      .knl_vgpr_per_wf           (knl_vgpr_per_wf),
      .knl_sgpr_per_wf           (knl_sgpr_per_wf),
      .knl_lds_total             (knl_lds_total),
      .host_req_valid            (host_req_valid),
      .host_req_ready            (host_req_ready),
      .host_req_wg_id            (host_req_wg_id),
      .host_req_num_wf           (host_req_num_wf),
      .host_req_wf_size          (host_req_wf_size),
      .host_req_start_pc         (host_req_start_pc),
      .host_req_pds_baseaddr     (host_req_pds_baseaddr),
      .host_req_csr_knl          (host_req_csr_knl),
      .host_req_vgpr_size_total  (host_req_vgpr_size_total),
      .host_req_sgpr_size_total  (host_req_sgpr_size_total),
      .host_req_lds_size_total   (host_req_lds_size_total),
      .host_req_vgpr_size_per_wf (host_req_vgpr_size_per_wf),
      .host_req_sgpr_size_per_wf (host_req_sgpr_size_per_wf),
      .host_rsp_valid            (host_rsp_valid),
      .host_rsp_ready            (host_rsp_ready),
      .host_rsp_wg_id            (host_rsp_wg_id),
      .busy                      (busy),
      .kernel_done               (kernel_done),
      .inflight_cnt              (inflight_cnt),
      .err                       (err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [8:0] nwg);
      knl_num_wg = nwg;
      knl_valid  = 1'b1;
      step();
      knl_valid  = 1'b0;
   endtask

   task automatic complete(input logic [7:0] id);
      host_rsp_valid = 1'b1;
      host_rsp_wg_id = id;
      step();
      host_rsp_valid = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check_eq({tag, "_valid"},    {63'd0, host_req_valid}, 64'd0);
      check_eq({tag, "_inflight"}, {60'd0, inflight_cnt},   64'd0);
      check_eq({tag, "_busy"},     {63'd0, busy},           64'd0);
      check_eq({tag, "_done"},     {63'd0, kernel_done},    64'd0);
      check_eq({tag, "_err"},      {63'd0, err},            64'd0);
      check_eq({tag, "_wgid"},     {56'd0, host_req_wg_id}, 64'd0);
      check_eq({tag, "_pds"},      {32'd0, host_req_pds_baseaddr}, 64'd0);
      check_eq({tag, "_vgprtot"},  {53'd0, host_req_vgpr_size_total}, 64'd0);
      check_eq({tag, "_knlrdy"},   {63'd0, knl_ready},      64'd1);
      check_eq({tag, "_rsprdy"},   {63'd0, host_rsp_ready}, 64'd1);
   endtask

   task automatic mid_reset(input string tag);
      #2 rst_n = 1'b0;
      #1 check_reset_values(tag);
      @(negedge clk) rst_n = 1'b1;
      step();
   endtask

   initial begin
      rst_n           = 1'b0;
      knl_valid       = 1'b0;
      knl_num_wg      = '0;
      knl_num_wf      = 3'd2;
      knl_wf_size     = 6'd32;
      knl_start_pc    = 32'h0000_1000;
      knl_pds_base    = 32'h9000_0000;
      knl_pds_stride  = 32'h0000_0100;
      knl_csr         = 32'h0000_2000;
      knl_vgpr_per_wf = 11'd16;
      knl_sgpr_per_wf = 11'd8;
      knl_lds_total   = 11'd100;
      host_req_ready  = 1'b1;
      host_rsp_valid  = 1'b0;
      host_rsp_wg_id  = '0;

      #3 check_reset_values("rst");
      @(negedge clk) rst_n = 1'b1;
      step();

      // Four workgroups back to back, completions 10 cycles after issue.
      launch(9'd4);
      check_eq("t1_sgprtot", {53'd0, host_req_sgpr_size_total}, 64'd16);
      check_eq("t1_lds",     {53'd0, host_req_lds_size_total},  64'd100);
      check_eq("t1_pc",      {32'd0, host_req_start_pc},        64'h1000);
      check_eq("t1_csr",     {32'd0, host_req_csr_knl},         64'h2000);
      check_eq("t1_numwf",   {61'd0, host_req_num_wf},          64'd2);
      check_eq("t1_wfsize",  {58'd0, host_req_wf_size},         64'd32);
      check_eq("t1_vgprpw",  {53'd0, host_req_vgpr_size_per_wf}, 64'd16);
      check_eq("t1_sgprpw",  {53'd0, host_req_sgpr_size_per_wf}, 64'd8);
      for (int i = 0; i < 4; i++) begin
         check_eq("t1_valid",   {63'd0, host_req_valid},           64'd1);
         check_eq("t1_wgid",    {56'd0, host_req_wg_id},           64'(i));
         check_eq("t1_pds",     {32'd0, host_req_pds_baseaddr},    64'h9000_0000 + 64'(i * 256));
         check_eq("t1_vgprtot", {53'd0, host_req_vgpr_size_total}, 64'd32);
         step();
      end
      check_eq("t1_drain_valid", {63'd0, host_req_valid}, 64'd0);
      check_eq("t1_drain_infl",  {60'd0, inflight_cnt},   64'd4);
      repeat (6) step();
      for (int k = 0; k < 4; k++) begin
         complete(8'(k));
         check_eq("t1_infl", {60'd0, inflight_cnt}, 64'(3 - k));
         check_eq("t1_done", {63'd0, kernel_done},  (k == 3) ? 64'd1 : 64'd0);
      end
      step();
      check_eq("t1_done_pulse", {63'd0, kernel_done}, 64'd0);
      check_eq("t1_knlrdy",     {63'd0, knl_ready},   64'd1);
      check_eq("t1_busy",       {63'd0, busy},        64'd0);
      check_eq("t1_err",        {63'd0, err},         64'd0);

      // Empty kernel.
      launch(9'd0);
      check_eq("t4_z_done",  {63'd0, kernel_done},    64'd1);
      check_eq("t4_z_valid", {63'd0, host_req_valid}, 64'd0);
      check_eq("t4_z_busy",  {63'd0, busy},           64'd1);
      step();
      check_eq("t4_z_done2", {63'd0, kernel_done},    64'd0);
      check_eq("t4_z_rdy",   {63'd0, knl_ready},      64'd1);

      // Credit limit: 12 workgroups, 8 credits, no completions.
      launch(9'd12);
      n_req = 0;
      for (int c = 0; c < 20; c++) begin
         if (host_req_valid && host_req_ready) n_req++;
         step();
      end
      check_eq("t2_nreq",  64'(n_req),                   64'd8);
      check_eq("t2_valid", {63'd0, host_req_valid},      64'd0);
      check_eq("t2_infl",  {60'd0, inflight_cnt},        64'd8);
      complete(8'd0);
      check_eq("t2_resume_valid", {63'd0, host_req_valid}, 64'd1);
      check_eq("t2_resume_wgid",  {56'd0, host_req_wg_id}, 64'd8);
      check_eq("t2_resume_infl",  {60'd0, inflight_cnt},   64'd7);

      // Back-pressure: payload frozen while not accepted.
      host_req_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         check_eq("t3_valid",   {63'd0, host_req_valid},           64'd1);
         check_eq("t3_wgid",    {56'd0, host_req_wg_id},           64'd8);
         check_eq("t3_pds",     {32'd0, host_req_pds_baseaddr},    64'h9000_0800);
         check_eq("t3_vgprtot", {53'd0, host_req_vgpr_size_total}, 64'd32);
      end
      host_req_ready = 1'b1;

      // Request and completion accepted on the same edge.
      complete(8'd1);
      check_eq("t4_same_infl", {60'd0, inflight_cnt},   64'd7);
      check_eq("t4_same_wgid", {56'd0, host_req_wg_id}, 64'd9);
      mid_reset("t2_rst");

      // Duplicate completion.
      launch(9'd3);
      repeat (3) step();
      check_eq("t6_infl3", {60'd0, inflight_cnt}, 64'd3);
      complete(8'd1);
      check_eq("t6_infl2", {60'd0, inflight_cnt}, 64'd2);
      check_eq("t6_err0",  {63'd0, err},          64'd0);
      complete(8'd1);
      check_eq("t6_dup_err",  {63'd0, err},          64'(CHK));
      check_eq("t6_dup_infl", {60'd0, inflight_cnt}, CHK ? 64'd2 : 64'd1);
      step();
      check_eq("t6_dup_sticky", {63'd0, err}, 64'(CHK));
      complete(8'd0);
      if (CHK) complete(8'd2);
      check_eq("t6_done",      {63'd0, kernel_done}, 64'd1);
      check_eq("t6_done_err",  {63'd0, err},         64'(CHK));
      step();
      check_eq("t6_idle_err",  {63'd0, err},         64'(CHK));
      launch(9'd3);
      check_eq("t6_clear_err", {63'd0, err},         64'd0);

      // Completion for a workgroup that was never issued.
      repeat (3) step();
      complete(8'd7);
      check_eq("t6_bad_err",  {63'd0, err},          64'(CHK));
      check_eq("t6_bad_infl", {60'd0, inflight_cnt}, CHK ? 64'd3 : 64'd2);
      mid_reset("t6_rst");

      // Reset during ISSUE after 3 workgroups, then restart from wg 0.
      launch(9'd5);
      repeat (3) step();
      check_eq("t5_pre_wgid", {56'd0, host_req_wg_id}, 64'd3);
      mid_reset("t5_rst");
      knl_num_wf      = 3'd7;
      knl_vgpr_per_wf = 11'h7FF;
      launch(9'd1);
      check_eq("t5_valid",   {63'd0, host_req_valid},           64'd1);
      check_eq("t5_wgid",    {56'd0, host_req_wg_id},           64'd0);
      check_eq("t5_pds",     {32'd0, host_req_pds_baseaddr},    64'h9000_0000);
      check_eq("t5_vgprtot", {53'd0, host_req_vgpr_size_total}, 64'h7F9);
      check_eq("t5_sgprtot", {53'd0, host_req_sgpr_size_total}, 64'd56);
      step();
      complete(8'd0);
      check_eq("t5_done", {63'd0, kernel_done}, 64'd1);
      step();
      check_eq("t5_idle", {63'd0, knl_ready},   64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
